// File: rtl/orbtrace_pkg.sv
// Shared types and constants for the orbtrace frame-to-byte datapath.
package orbtrace_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        BODY,
        STATS
    } state_t;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [3:0]  HDR_NIBBLE        = 4'h5;
    localparam logic [7:0]  STATS_TAG         = 8'h5F;

    localparam int unsigned FRAME_REC_LEN = 18;
    localparam int unsigned STATS_REC_LEN = 6;

    localparam int unsigned FRAME_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 32;

endpackage

// File: rtl/frame_byte_serialiser_if.sv
// Frame-buffer pop handshake and UART byte handshake bundled together.
interface frame_byte_serialiser_if #(
    parameter int unsigned BUFFLENLOG2 = 9
) ();

    logic [127:0]           Frame;
    logic                   FrameReady;
    logic [BUFFLENLOG2-1:0] FramesCnt;
    logic                   FrameNext;
    logic [7:0]             DataVal;
    logic                   DataReady;
    logic                   DataNext;

    // Serialiser side
    modport master (
        input  Frame,
        input  FrameReady,
        input  FramesCnt,
        input  DataNext,
        output FrameNext,
        output DataVal,
        output DataReady
    );

    // Buffer / UART side
    modport slave (
        output Frame,
        output FrameReady,
        output FramesCnt,
        output DataNext,
        input  FrameNext,
        input  DataVal,
        input  DataReady
    );

endinterface

// File: rtl/frame_byte_serialiser.sv
// Serialises 128-bit trace frames into 18-byte records (sync, width header,
// 16 body bytes LSB first) on a valid/accept byte interface.
// Optional STATS_INSERT_EN: every STATS_INTERVAL frames a 6-byte stats record
// (sync, tag, 32-bit sent-frame count LSB first) follows the frame record.
module frame_byte_serialiser
    import orbtrace_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned STATS_INTERVAL = 256
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [1:0]                     Width,
    frame_byte_serialiser_if.master        bus,
    output logic                           Transmitting,
    output logic [31:0]                    SentFrames
);

    localparam logic [IDX_W-1:0] BODY_LAST = IDX_W'(FRAME_REC_LEN - 3);

`ifdef STATS_INSERT_EN
    localparam int unsigned STATS_CNT_W = (STATS_INTERVAL > 1) ? $clog2(STATS_INTERVAL) : 1;
    localparam logic [STATS_CNT_W-1:0] STATS_LAST_CNT = STATS_CNT_W'(STATS_INTERVAL - 1);
    localparam logic [IDX_W-1:0] STATS_LAST = IDX_W'(STATS_REC_LEN - 1);

    logic [STATS_CNT_W-1:0] frm_cnt_q, frm_cnt_d;
`endif

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [1:0]         width_q, width_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               frame_next_q, frame_next_d;
    logic [BYTE_W-1:0]  data_val_q, data_val_d;
    logic               data_ready_q, data_ready_d;
    logic               transmitting_q, transmitting_d;
    logic               xfer;
    logic               fetch;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        width_d      = width_q;
        idx_d        = idx_q;
        sent_d       = sent_q;
        frame_next_d = 1'b0;
        fetch        = 1'b0;
`ifdef STATS_INSERT_EN
        frm_cnt_d    = frm_cnt_q;
`endif
        xfer         = data_ready_q & bus.DataNext;

        case (state_q)
            IDLE: fetch = 1'b1;
            HDR0: if (xfer) state_d = HDR1;
            HDR1: begin
                if (xfer) begin
                    state_d = BODY;
                    idx_d   = '0;
                end
            end
            BODY: begin
                if (xfer) begin
                    shift_d = shift_q >> BYTE_W;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == BODY_LAST) begin
                        sent_d = sent_q + CNT_W'(1);
`ifdef STATS_INSERT_EN
                        if (frm_cnt_q == STATS_LAST_CNT) begin
                            frm_cnt_d = '0;
                            state_d   = STATS;
                            idx_d     = '0;
                            shift_d   = FRAME_W'({sent_d, STATS_TAG, SYNC_BYTE});
                        end else begin
                            frm_cnt_d = frm_cnt_q + STATS_CNT_W'(1);
                            fetch     = 1'b1;
                        end
`else
                        fetch = 1'b1;
`endif
                    end
                end
            end
`ifdef STATS_INSERT_EN
            STATS: begin
                if (xfer) begin
                    shift_d = shift_q >> BYTE_W;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == STATS_LAST) fetch = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Record boundary: pull the next frame back-to-back or fall idle
        if (fetch) begin
            if (bus.FrameReady) begin
                shift_d      = bus.Frame;
                width_d      = Width;
                frame_next_d = 1'b1;
                state_d      = HDR0;
            end else begin
                state_d = IDLE;
            end
        end

        case (state_d)
            HDR0:        data_val_d = SYNC_BYTE;
            HDR1:        data_val_d = {HDR_NIBBLE, 2'b00, width_d};
            BODY, STATS: data_val_d = shift_d[BYTE_W-1:0];
            default:     data_val_d = '0;
        endcase
        data_ready_d   = (state_d != IDLE);
        transmitting_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            width_q        <= '0;
            idx_q          <= '0;
            sent_q         <= '0;
            frame_next_q   <= 1'b0;
            data_val_q     <= '0;
            data_ready_q   <= 1'b0;
            transmitting_q <= 1'b0;
`ifdef STATS_INSERT_EN
            frm_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            width_q        <= width_d;
            idx_q          <= idx_d;
            sent_q         <= sent_d;
            frame_next_q   <= frame_next_d;
            data_val_q     <= data_val_d;
            data_ready_q   <= data_ready_d;
            transmitting_q <= transmitting_d;
`ifdef STATS_INSERT_EN
            frm_cnt_q      <= frm_cnt_d;
`endif
        end
    end

    assign bus.FrameNext = frame_next_q;
    assign bus.DataVal   = data_val_q;
    assign bus.DataReady = data_ready_q;
    assign Transmitting  = transmitting_q;
    assign SentFrames    = sent_q;

endmodule

// File: tb/tb_frame_byte_serialiser.sv
// Self-checking bench: queue-based frame buffer and record-level byte model.
module tb_frame_byte_serialiser;

    localparam int unsigned BUFFLENLOG2 = 9;
    localparam int unsigned STATS_INTERVAL_TB = 4;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  Width;
    logic        Transmitting;
    logic [31:0] SentFrames;

    frame_byte_serialiser_if #(.BUFFLENLOG2(BUFFLENLOG2)) bus ();

    frame_byte_serialiser #(.STATS_INTERVAL(STATS_INTERVAL_TB)) u_dut (
        .clk          (clk),
        .rstn         (rstn),
        .Width        (Width),
        .bus          (bus),
        .Transmitting (Transmitting),
        .SentFrames   (SentFrames)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          fn_count = 0;
    int          fn_popped = 0;
    int          dn_mode = 0;
    bit          rand_width = 1'b0;
    logic [127:0] fq[$];
    bit          dn_pat[$];
    exp_t        exp_q[$];
    exp_t        pend_q[$];
    logic [7:0]  got_bytes[$];
    int          got_cyc[$];
    logic [31:0] exp_sent = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
        end
    endtask

    // Buffer model output: head of queue
    task automatic drive_buf();
        bus.FramesCnt  = BUFFLENLOG2'(fq.size());
        bus.FrameReady = (bus.FramesCnt != '0);
        bus.Frame      = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // One clock: act on pops seen, then drive DataNext/Width for the next edge
    task automatic step();
        @(posedge clk);
        #1;
        while (fn_popped != fn_count) begin
            if (fq.size() != 0) fq.delete(0);
            fn_popped++;
        end
        drive_buf();
        case (dn_mode)
            1:       bus.DataNext = 1'($urandom_range(0, 1));
            2:       bus.DataNext = (dn_pat.size() != 0) ? dn_pat.pop_front() : 1'b1;
            default: bus.DataNext = 1'b1;
        endcase
        if (rand_width) Width = 2'($urandom_range(0, 3));
    endtask

    task automatic add_frame_rec(input logic [127:0] f, input logic [1:0] w);
        pend_q.push_back(exp_t'{b: 8'hA5, last: 1'b0});
        pend_q.push_back(exp_t'{b: 8'h50 | {6'b0, w}, last: 1'b0});
        for (int i = 0; i < 16; i++)
            pend_q.push_back(exp_t'{b: f[8*i +: 8], last: (i == 15)});
    endtask

    // Model and compare process, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        bit   fn_exp;
        cyc++;
        if (!rstn) begin
            exp_q.delete();
            pend_q.delete();
            exp_sent = '0;
            chk("rst_data_ready", 32'(bus.DataReady), 32'd0);
            chk("rst_frame_next", 32'(bus.FrameNext), 32'd0);
            chk("rst_transmitting", 32'(Transmitting), 32'd0);
            chk("rst_sent_frames", SentFrames, 32'd0);
            chk("rst_data_val", 32'(bus.DataVal), 32'd0);
        end else begin
            fn_exp = (pend_q.size() != 0);
            while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
            chk("frame_next", 32'(bus.FrameNext), 32'(fn_exp));
            chk("data_ready", 32'(bus.DataReady), 32'(exp_q.size() != 0));
            chk("transmitting", 32'(Transmitting), 32'(exp_q.size() != 0));
            chk("sent_frames", SentFrames, exp_sent);
            if (exp_q.size() != 0) chk("data_val", 32'(bus.DataVal), 32'(exp_q[0].b));
            if (bus.FrameNext) fn_count++;
            if (bus.DataReady && bus.DataNext) begin
                got_bytes.push_back(bus.DataVal);
                got_cyc.push_back(cyc);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.last) begin
                        exp_sent = exp_sent + 32'd1;
`ifdef STATS_INSERT_EN
                        if (exp_sent % STATS_INTERVAL_TB == 0) begin
                            exp_q.push_back(exp_t'{b: 8'hA5, last: 1'b0});
                            exp_q.push_back(exp_t'{b: 8'h5F, last: 1'b0});
                            for (int k = 0; k < 4; k++)
                                exp_q.push_back(exp_t'{b: exp_sent[8*k +: 8], last: 1'b0});
                        end
`endif
                    end
                end
            end
            if (exp_q.size() == 0 && bus.FrameReady) add_frame_rec(bus.Frame, Width);
        end
    end

    task automatic wait_bytes(input string nm, input int n, input int budget);
        for (int c = 0; c < budget && got_bytes.size() < n; c++) step();
        chk(nm, 32'(got_bytes.size()), 32'(n));
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < budget && !idle; c++) begin
            step();
            idle = (fq.size() == 0) && (exp_q.size() == 0) && (pend_q.size() == 0) && !bus.DataReady;
        end
        chk(nm, 32'(idle), 32'd1);
    endtask

    initial begin
        int b;
        int fb;
        logic [127:0] f;
        rstn         = 1'b0;
        Width        = 2'b11;
        bus.DataNext = 1'b0;
        drive_buf();
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();

        // Single frame, full-rate sink
        b = got_bytes.size(); fb = fn_count;
        fq.push_back(128'h0F0E0D0C0B0A09080706050403020100);
        drive_buf();
        wait_idle("t1_idle", 200);
        chk("t1_len", 32'(got_bytes.size() - b), 32'd18);
        chk("t1_sync", 32'(got_bytes[b]), 32'hA5);
        chk("t1_hdr", 32'(got_bytes[b+1]), 32'h53);
        for (int i = 0; i < 16; i++) chk("t1_body", 32'(got_bytes[b+2+i]), 32'(i));
        chk("t1_pulses", 32'(fn_count - fb), 32'd1);
        chk("t1_sent", SentFrames, 32'd1);

        // Two frames back to back
        b = got_bytes.size(); fb = fn_count;
        fq.push_back({4{$urandom}});
        fq.push_back({4{$urandom}});
        drive_buf();
        wait_idle("t2_idle", 200);
        chk("t2_len", 32'(got_bytes.size() - b), 32'd36);
        chk("t2_gapless", 32'(got_cyc[b+35] - got_cyc[b]), 32'd35);
        chk("t2_pulses", 32'(fn_count - fb), 32'd2);
        chk("t2_sent", SentFrames, 32'd3);

        // Backpressure during BODY
        b = got_bytes.size();
        fq.push_back(128'hFFEEDDCCBBAA99887766554433221100);
        drive_buf();
        wait_bytes("t3_reach_body", b + 4, 100);
        dn_mode = 2;
        dn_pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        wait_idle("t3_idle", 200);
        dn_mode = 0;
        chk("t3_len", 32'(got_bytes.size() - b), 32'd18);
        for (int i = 0; i < 16; i++) chk("t3_body", 32'(got_bytes[b+2+i]), 32'(i * 8'h11));

        // Width change mid-record
        b = got_bytes.size();
        Width = 2'b11;
        fq.push_back({4{$urandom}});
        fq.push_back({4{$urandom}});
        drive_buf();
        wait_bytes("t4_reach_body", b + 5, 100);
        Width = 2'b01;
        wait_idle("t4_idle", 200);
        chk("t4_hdr1", 32'(got_bytes[b+1]), 32'h53);
        chk("t4_hdr2", 32'(got_bytes[b+19]), 32'h51);

        // Reset at body index 7
        b = got_bytes.size();
        fq.push_back({4{$urandom}});
        drive_buf();
        wait_bytes("t5_reach_idx7", b + 9, 100);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_ready_drop", 32'(bus.DataReady), 32'd0);
        chk("t5_sent_clear", SentFrames, 32'd0);
        repeat (2) step();
        fq.push_back(128'h00000000000000000000000000C3A53C);
        drive_buf();
        step();
        rstn = 1'b1;
        b = got_bytes.size();
        wait_idle("t5_idle", 200);
        chk("t5_len", 32'(got_bytes.size() - b), 32'd18);
        chk("t5_sync", 32'(got_bytes[b]), 32'hA5);
        chk("t5_fresh", 32'(got_bytes[b+2]), 32'h3C);
        chk("t5_sent", SentFrames, 32'd1);

`ifdef STATS_INSERT_EN
        // Stats record after the fourth frame
        rstn = 1'b0;
        repeat (2) step();
        rstn = 1'b1;
        b = got_bytes.size();
        for (int i = 0; i < 4; i++) fq.push_back({4{$urandom}});
        drive_buf();
        wait_idle("t6_idle", 400);
        chk("t6_len", 32'(got_bytes.size() - b), 32'd78);
        chk("t6_s0", 32'(got_bytes[b+72]), 32'hA5);
        chk("t6_s1", 32'(got_bytes[b+73]), 32'h5F);
        chk("t6_s2", 32'(got_bytes[b+74]), 32'h04);
        chk("t6_s3", 32'(got_bytes[b+75]), 32'h00);
        chk("t6_s4", 32'(got_bytes[b+76]), 32'h00);
        chk("t6_s5", 32'(got_bytes[b+77]), 32'h00);
`endif

        // Randomised traffic: random sink stalls, random widths, random arrival
        fb = fn_count;
        dn_mode    = 1;
        rand_width = 1'b1;
        for (int n = 0; n < 12; n++) begin
            f = {$urandom, $urandom, $urandom, $urandom};
            fq.push_back(f);
            drive_buf();
            repeat ($urandom_range(0, 30)) step();
        end
        wait_idle("t7_idle", 3000);
        rand_width = 1'b0;
        dn_mode    = 0;
        chk("t7_pulses", 32'(fn_count - fb), 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_byte_serialiser.md
Name: frame_byte_serialiser

Overview:
- Sits between the frame buffer and the UART transceiver in the orbtrace datapath.
- Pulls 128-bit trace frames from the buffer using its FrameNext/FrameReady handshake.
- Emits each frame as an 18-byte record: a 2-byte sync/width header, then 16 body bytes.
- Drives the UART byte interface using a valid/accept handshake.

Parameters:
- BUFFLENLOG2, 9, width of the frames-available count input.
- SYNC_BYTE, 8'hA5, first byte of every record.
- STATS_INTERVAL, 256, frames between stats records (only used when STATS_INSERT_EN is defined).

Ports:
- clk  in  1  system clock (192 MHz PLL output).
- rstn  in  1  reset; asynchronous, active-low.
- Width  in  2  current trace port width code.
- Frame  in  128  head frame from the frame buffer.
- FrameReady  in  1  head frame is valid.
- FramesCnt  in  BUFFLENLOG2  frames available (status only).
- FrameNext  out  1  one-cycle pulse; pops the head frame.
- DataVal  out  8  byte offered to the UART.
- DataReady  out  1  DataVal is valid.
- DataNext  in  1  UART accepts the byte (sink ready).
- Transmitting  out  1  high whenever the FSM is not in IDLE.
- SentFrames  out  32  count of frames fully transmitted.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State is IDLE.
  - FrameNext, DataReady, Transmitting and SentFrames are 0; DataVal is 8'h00.
  - Shift register and byte index are cleared.
  - A record in progress is discarded and never resumed.
- Byte handshake:
  - A byte transfers on any rising edge where DataReady and DataNext are both 1.
  - While DataReady=1 and DataNext=0, DataVal is held stable.
  - DataReady never drops without a transfer, except on reset.
- State IDLE:
  - If FrameReady=1, on that edge: latch Frame into a 128-bit shift register and Width into a 2-bit width register.
  - FrameNext is 1 for exactly that one cycle.
  - Then go to HDR0.
  - Latency: FrameReady sampled high in IDLE gives DataReady=1 with SYNC_BYTE on the next cycle.
- State HDR0: DataVal=SYNC_BYTE. On transfer, go to HDR1.
- State HDR1: DataVal={4'h5,2'b00,width_latched}. On transfer, go to BODY with the byte index set to 0.
- State BODY:
  - DataVal=shift[7:0], so the frame goes LSB first.
  - On each transfer, shift right by 8 and increment the 4-bit index.
  - On the transfer at index 15:
    - SentFrames increments, wrapping at 2^32.
    - If FrameReady=1 on that same edge, latch the next frame, pulse FrameNext and go to HDR0, with no idle bubble.
    - Otherwise go to IDLE.
- FrameNext is never asserted while FrameReady=0.
- FrameNext is never asserted twice for one frame; the buffer updates Frame one cycle after the pulse.
- A Width change mid-record has no effect; the header uses the latched width.
- FramesCnt does not affect control flow. It may be left unused except for the optional feature.

Optional Feature:
- Macro: STATS_INSERT_EN.
- Defined:
  - A frame counter (log2(STATS_INTERVAL) bits) increments with SentFrames.
  - When it wraps to 0, the FSM goes to STATS after the last body byte.
  - The frame counter wraps and restarts, so every STATS_INTERVAL frames the 6-byte stats record is emitted.
  - The stats record is 6 bytes: SYNC_BYTE, 8'h5F, then SentFrames (post-increment) in 4 bytes, LSB first.
  - The SentFrames value is snapshotted on entry to STATS.
  - After the stats record, the back-to-back rule of BODY applies: FrameReady=1 latches the next frame and goes to HDR0, otherwise go to IDLE.
  - The stats record is never emitted mid-frame.
- Not defined: the STATS state and the frame counter are absent, and the output is frame records only.

Decomposition:
- Shared package (orbtrace_pkg) holds:
  - the state enum (IDLE, HDR0, HDR1, BODY, STATS);
  - the SYNC_BYTE default;
  - the header nibble 4'h5 and stats tag 8'h5F;
  - the record lengths (18 and 6).
- No sub-module: a flat FSM plus the shift register fits comfortably.
- The UART-side handshake logic must stay in this block.

Test Plan:
- Single frame 128'h0F0E...0100 with Width=2'b11 and DataNext held 1 -> bytes A5, 53, 00, 01, …, 0F; one FrameNext pulse; SentFrames=1; back to IDLE.
- Two frames queued with DataNext=1 -> 36 consecutive bytes with no DataReady gap between records; exactly two FrameNext pulses.
- Backpressure: DataNext toggles 1,0,0,1 during BODY -> DataVal stable across the stalls; no byte dropped or duplicated; order intact.
- Width changes 11 -> 01 during BODY of frame 1 -> frame 1 header is 53; frame 2 header is 51.
- rstn asserted at body index 7 and released -> DataReady=0 immediately; next record starts at A5 with a fresh frame; SentFrames=0.
- STATS_INSERT_EN with STATS_INTERVAL=4, 4 frames queued -> after frame 4, bytes A5, 5F, 04, 00, 00, 00.
